// File: rtl/tx_byte_streamer.sv
// Streams `length` bytes from a synchronous-read byte memory into a UART TX core,
// counting completed bytes on tx_done rising edges and pulsing `done` at the end.
module tx_byte_streamer #(
  parameter int MAX_COUNT = 65536,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       length,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [31:0]       byte_count,
  output logic              busy,
  output logic              done
);

  localparam logic [31:0]       MAX_LEN  = 32'(MAX_COUNT);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_LATCH   = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [7:0]        tx_data_s;
  logic              tx_start_s;
  logic [31:0]       byte_count_s;
  logic              busy_s;
  logic              done_s;
  logic [31:0]       eff_len_r;
  logic [31:0]       eff_len_s;
  logic [31:0]       req_len_s;
  logic [31:0]       count_inc_s;
  logic              tx_done_prev_r;
  logic              done_edge_s;

  function automatic logic [31:0] clamp_len(input logic [31:0] len);
    if (len > MAX_LEN) begin
      return MAX_LEN;
    end else begin
      return len;
    end
  endfunction

  // Next-state and next-output decode for the transfer sequencer.
  always_comb begin
    req_len_s    = clamp_len(length);
    done_edge_s  = tx_done & ~tx_done_prev_r;
    count_inc_s  = byte_count + 32'd1;
    state_s      = state_r;
    mem_addr_s   = mem_addr;
    tx_data_s    = tx_data;
    tx_start_s   = 1'b0;
    byte_count_s = byte_count;
    busy_s       = busy;
    done_s       = 1'b0;
    eff_len_s    = eff_len_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          eff_len_s    = req_len_s;
          byte_count_s = 32'd0;
          if (req_len_s != 32'd0) begin
            mem_addr_s = {ADDR_W{1'b0}};
            busy_s     = 1'b1;
            state_s    = ST_READ;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        tx_data_s = mem_rdata;
        state_s   = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_start_s = 1'b1;
          state_s    = ST_WAIT_TX;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT_TX: begin
        // Only a fresh rising edge of tx_done retires the byte in flight.
        if (done_edge_s) begin
          byte_count_s = count_inc_s;
          if (count_inc_s == eff_len_r) begin
            state_s = ST_DONE;
          end else begin
            mem_addr_s = mem_addr + ADDR_ONE;
            state_s    = ST_READ;
          end
        end else begin
          state_s = ST_WAIT_TX;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; tx_done_prev resets high to mask a post-reset edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      mem_addr       <= {ADDR_W{1'b0}};
      tx_data        <= 8'd0;
      tx_start       <= 1'b0;
      byte_count     <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      eff_len_r      <= 32'd0;
      tx_done_prev_r <= 1'b1;
    end else begin
      state_r        <= state_s;
      mem_addr       <= mem_addr_s;
      tx_data        <= tx_data_s;
      tx_start       <= tx_start_s;
      byte_count     <= byte_count_s;
      busy           <= busy_s;
      done           <= done_s;
      eff_len_r      <= eff_len_s;
      tx_done_prev_r <= tx_done;
    end
  end

endmodule
